// File: rtl/btn_event_ctrl_if.sv
// Event port of btn_event_ctrl: one button event per valid/ready handshake.
interface btn_event_ctrl_if #(
    parameter int IDW = 2
) ();
    logic           evt_valid;
    logic           evt_ready;
    logic [IDW-1:0] evt_id;
    logic [1:0]     evt_kind;

    modport master (output evt_valid, output evt_id, output evt_kind, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_kind, output evt_ready);
endinterface

// File: rtl/btn_event_ctrl.sv
// Debounce-and-event controller: shared tick prescaler, per-button stability
// filters and hold timers, round-robin arbitration onto one event port.
module btn_event_ctrl #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int TICK_DIV = 50000,
    parameter int STABLE   = 4,
    parameter int LONG     = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     btn,
    output logic [N-1:0]     state,
    output logic             overflow,
    input  logic             ovf_clr,
    btn_event_ctrl_if.master evt
);
    typedef enum logic [1:0] {
        KIND_PRESS   = 2'b01,
        KIND_RELEASE = 2'b10,
        KIND_LONG    = 2'b11
    } kind_e;

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [N-1:0]       sync_q, bs;
    logic [CW-1:0]      cnt;
    logic               tick;
    logic [N-1:0][3:0]  agree, agree_d;
    logic [N-1:0][7:0]  hold, hold_d;
    logic [N-1:0]       state_d;
    logic [N-1:0]       pend_p, pend_l, pend_r;
    logic [N-1:0]       set_p, set_l, set_r;
    logic [N-1:0]       gnt_p, gnt_l, gnt_r;
    logic [IDW-1:0]     last;
    logic [IDW-1:0]     sel_id;
    kind_e              sel_kind;
    logic               load, found, drop;

    assign tick = (cnt == CW'(TICK_DIV - 1));
    assign load = !evt.evt_valid || evt.evt_ready;
    assign drop = |((set_p & pend_p & ~gnt_p) |
                    (set_l & pend_l & ~gnt_l) |
                    (set_r & pend_r & ~gnt_r));

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        agree_d = agree;
        hold_d  = hold;
        set_p   = '0;
        set_l   = '0;
        set_r   = '0;
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                if (state[i]) begin
                    if (hold[i] != 8'd255) hold_d[i] = hold[i] + 8'd1;
                    if (hold[i] == 8'(LONG - 1)) set_l[i] = 1'b1;
                end
                if (bs[i] != state[i]) begin
                    if (agree[i] == 4'(STABLE - 1)) begin
                        state_d[i] = bs[i];
                        agree_d[i] = '0;
                        if (bs[i]) begin
                            set_p[i]  = 1'b1;
                            hold_d[i] = '0;
                        end else begin
                            set_r[i] = 1'b1;
                        end
                    end else begin
                        agree_d[i] = agree[i] + 4'd1;
                    end
                end else begin
                    agree_d[i] = '0;
                end
            end
        end
    end

    // Round-robin pick: smallest rotational distance from the last granted id.
    always_comb begin
        int best_d;
        int d;
        best_d   = N;
        d        = 0;
        sel_id   = '0;
        sel_kind = KIND_PRESS;
        gnt_p    = '0;
        gnt_l    = '0;
        gnt_r    = '0;
        for (int i = 0; i < N; i++) begin
            d = (i + 2 * N - 1 - int'(last)) % N;
            if ((pend_p[i] || pend_l[i] || pend_r[i]) && d < best_d) begin
                best_d = d;
                sel_id = IDW'(i);
            end
        end
        found = (best_d < N);
        for (int i = 0; i < N; i++) begin
            if (load && found && sel_id == IDW'(i)) begin
                if (pend_p[i]) begin
                    gnt_p[i] = 1'b1;
                    sel_kind = KIND_PRESS;
                end else if (pend_l[i]) begin
                    gnt_l[i] = 1'b1;
                    sel_kind = KIND_LONG;
                end else begin
                    gnt_r[i] = 1'b1;
                    sel_kind = KIND_RELEASE;
                end
            end
        end
    end

    // NOTE: the per-button filter arrays are reset too, so a reset mid-event leaves nothing half-counted or pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q        <= '0;
            bs            <= '0;
            cnt           <= '0;
            state         <= '0;
            agree         <= '0;
            hold          <= '0;
            pend_p        <= '0;
            pend_l        <= '0;
            pend_r        <= '0;
            last          <= IDW'(N - 1);
            overflow      <= 1'b0;
            evt.evt_valid <= 1'b0;
            evt.evt_id    <= '0;
            evt.evt_kind  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values regardless of statement order.
            sync_q   <= btn;
            bs       <= sync_q;
            cnt      <= tick ? '0 : cnt + 1'b1;
            state    <= state_d;
            agree    <= agree_d;
            hold     <= hold_d;
            pend_p   <= (pend_p & ~gnt_p) | set_p;
            pend_l   <= (pend_l & ~gnt_l) | set_l;
            pend_r   <= (pend_r & ~gnt_r) | set_r;
            overflow <= drop | (overflow & ~ovf_clr);
            if (load) begin
                evt.evt_valid <= found;
                if (found) begin
                    evt.evt_id   <= sel_id;
                    evt.evt_kind <= sel_kind;
                    last         <= sel_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl: directed scenarios plus random
// stimulus, scored against a tick-level behavioural model through an event queue.
`timescale 1ns/1ps
module tb_btn_event_ctrl;
    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int TICK_DIV = 4;
    localparam int STABLE   = 3;
    localparam int LONG     = 5;

    localparam int K_PRESS = 1, K_RELEASE = 2, K_LONG = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] state;
    logic         overflow;
    logic         ovf_clr = 1'b0;

    btn_event_ctrl_if #(.IDW(IDW)) evt ();

    btn_event_ctrl #(
        .N(N), .IDW(IDW), .TICK_DIV(TICK_DIV), .STABLE(STABLE), .LONG(LONG)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .state(state),
        .overflow(overflow), .ovf_clr(ovf_clr), .evt(evt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: levels flip after STABLE consecutive opposite samples,
    // events kept as per-button pending sets, served round-robin.
    typedef struct { int id; int kind; } ev_t;
    ev_t exp_q[$];

    int              m_cnt;
    bit [N-1:0]      m_s1, m_bs, m_state;
    bit [STABLE-1:0] m_hist [N];
    int              m_held [N];
    bit              m_pend [N][4];
    int              m_last;
    bit              m_valid;
    bit              m_ovf;
    bit              m_drop;

    task automatic model_reset();
        m_cnt = 0; m_s1 = '0; m_bs = '0; m_state = '0;
        m_last = N - 1; m_valid = 0; m_ovf = 0;
        for (int i = 0; i < N; i++) begin
            m_hist[i] = '0;
            m_held[i] = 0;
            for (int k = 0; k < 4; k++) m_pend[i][k] = 0;
        end
        exp_q.delete();
    endtask

    task automatic raise(input int b, input int kind);
        if (m_pend[b][kind]) m_drop = 1;
        else m_pend[b][kind] = 1;
    endtask

    task automatic model_step();
        bit was;
        m_drop = 0;
        if (!m_valid || evt.evt_ready) begin
            m_valid = 0;
            for (int k = 0; k < N; k++) begin
                int b, kd;
                b  = (m_last + 1 + k) % N;
                kd = m_pend[b][K_PRESS] ? K_PRESS : m_pend[b][K_LONG] ? K_LONG :
                     m_pend[b][K_RELEASE] ? K_RELEASE : 0;
                if (kd != 0) begin
                    ev_t e;
                    e.id = b; e.kind = kd;
                    m_pend[b][kd] = 0;
                    exp_q.push_back(e);
                    m_last  = b;
                    m_valid = 1;
                    break;
                end
            end
        end
        if (m_cnt == TICK_DIV - 1) begin
            for (int i = 0; i < N; i++) begin
                was = m_state[i];
                m_hist[i] = {m_hist[i][STABLE-2:0], m_bs[i]};
                if (was && m_held[i] < 255) begin
                    m_held[i]++;
                    if (m_held[i] == LONG) raise(i, K_LONG);
                end
                if (m_hist[i] == {STABLE{~was}}) begin
                    m_state[i] = ~was;
                    if (!was) begin
                        m_held[i] = 0;
                        raise(i, K_PRESS);
                    end else begin
                        raise(i, K_RELEASE);
                    end
                end
            end
        end
        m_cnt = (m_cnt + 1) % TICK_DIV;
        if (m_drop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        m_bs = m_s1;
        m_s1 = btn;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    // Monitor: compare outputs mid-cycle; the queue front is the event on display.
    always @(negedge clk) begin
        check("evt_valid", evt.evt_valid, m_valid);
        check("state", state, m_state);
        check("overflow", overflow, m_ovf);
        if (evt.evt_valid) begin
            check("evt_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("evt_id", evt.evt_id, exp_q[0].id);
                check("evt_kind", evt.evt_kind, exp_q[0].kind);
                if (evt.evt_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int waited;
        evt.evt_ready = 1'b0;
        do_reset();

        // Reset mid-event: outputs drop at once, nothing follows.
        btn[1] = 1'b1;
        waited = 0;
        while (!evt.evt_valid && waited < 100) begin
            cycles(1);
            waited++;
        end
        check("rst_setup_valid", evt.evt_valid, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_evt_valid", evt.evt_valid, 0);
        check("rst_evt_id", evt.evt_id, 0);
        check("rst_evt_kind", evt.evt_kind, 0);
        check("rst_state", state, 0);
        check("rst_overflow", overflow, 0);
        btn = '0;
        cycles(3);
        rst = 1'b0;
        evt.evt_ready = 1'b1;
        cycles(60);

        // Clean press on btn[1]: press, long, release.
        btn[1] = 1'b1;
        cycles(40);
        btn[1] = 1'b0;
        cycles(30);

        // Bounce on btn[0], then steady press and release.
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            cycles(3);
        end
        btn[0] = 1'b1;
        cycles(40);
        btn[0] = 1'b0;
        cycles(30);

        // Simultaneous presses from a fresh round-robin pointer.
        do_reset();
        btn = 4'b1101;
        cycles(30);
        btn = '0;
        cycles(30);
        btn = 4'b0101;
        cycles(30);
        btn = '0;
        cycles(30);

        // Backpressure on btn[2] until events collide.
        evt.evt_ready = 1'b0;
        btn[2] = 1'b1;
        cycles(40);
        btn[2] = 1'b0;
        cycles(20);
        btn[2] = 1'b1;
        cycles(40);
        btn[2] = 1'b0;
        cycles(20);
        check("bp_overflow_set", overflow, 1);
        evt.evt_ready = 1'b1;
        cycles(20);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        cycles(2);
        check("bp_overflow_cleared", overflow, 0);

        // One-tick glitch on btn[3].
        btn[3] = 1'b1;
        cycles(TICK_DIV);
        btn[3] = 1'b0;
        cycles(30);
        check("glitch_state", state[3], 0);

        // Random levels, random backpressure, occasional overflow clears.
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            btn = N'($urandom);
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                evt.evt_ready = ($urandom_range(0, 3) != 0);
                ovf_clr       = ($urandom_range(0, 50) == 0);
                cycles(1);
            end
        end

        // Drain.
        btn = '0;
        ovf_clr = 1'b0;
        evt.evt_ready = 1'b1;
        cycles(100);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_valid_low", evt.evt_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Debounce-and-event controller for a bank of mechanical push-buttons. One shared sample-tick prescaler schedules per-button stability filters and hold timers, and a round-robin arbiter serialises the resulting press, long-press and release events onto a single valid/ready event port. It sits between the raw board inputs and the user-interface logic, which consumes one event per handshake.

## Interface
- `N`, default 4: number of buttons.
- `IDW`, default 2: event id width; must satisfy 2^IDW ≥ N.
- `TICK_DIV`, default 50000: clk cycles per sample tick; ≥ 2.
- `STABLE`, default 4: consecutive disagreeing ticks needed to flip a debounced level; 1..15.
- `LONG`, default 100: ticks held before a long-press event; 1..255.
- `clk` in 1: the only clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `btn` in N: raw button levels, asynchronous, 1 = pressed.
- `state` out N: debounced levels.
- `evt_valid` out 1: event available.
- `evt_ready` in 1: consumer accepts the event.
- `evt_id` out IDW: button index of the event.
- `evt_kind` out 2: 01 = press, 10 = release, 11 = long press; 00 is never emitted while valid.
- `overflow` out 1: sticky flag; set when an event is dropped.
- `ovf_clr` in 1: synchronous clear of `overflow`.

## Operation
- **Synchroniser.** Each `btn` bit passes through 2 flops (`bs`) before any use.
- **Prescaler.** The counter runs 0..TICK_DIV-1 and wraps. `tick` = (count == TICK_DIV-1), one cycle wide.
- **Filter, per button, on tick edges only.**
  - If `bs` ≠ `state`: `agree` increments.
  - If `agree` reaches STABLE-1 on this tick: `state` ← `bs` and `agree` ← 0.
  - If `bs` = `state`: `agree` ← 0. Any matching sample restarts the count.
- **Edge handling.**
  - 0→1 sets pending-press and clears `hold`.
  - 1→0 sets pending-release.
- **Hold timer.**
  - While `state` = 1, each tick increments `hold`, saturating at 255.
  - The tick on which `hold` becomes LONG sets pending-long. This happens once per press.
- **Pending bits.** Each button has three pending bits, press/long/release.
  - Setting a bit that is already set (and not being granted that cycle) drops the new event and sets `overflow`.
  - If set and grant of the same bit occur in one cycle, the bit stays set and no overflow is raised.
- **Arbiter.**
  - The output register loads when `!evt_valid || evt_ready`.
  - Button selection: the first button with any pending bit, searching from (last granted id + 1) mod N.
  - Kind priority within a button: press > long > release.
  - Loading the output clears the selected pending bit.
  - If nothing is pending, `evt_valid` ← 0.
- **Output stability.** `evt_id` and `evt_kind` are stable while `evt_valid && !evt_ready`.
- **Overflow flag.** `ovf_clr` clears `overflow` unless a drop occurs in the same cycle; the set wins.
- **Reset values.** `rst` clears prescaler, `agree`, `hold`, `state`, pending bits, RR pointer (last = N-1, so button 0 is searched first), `evt_valid`, `evt_id`, `evt_kind` and `overflow` to 0. Reset mid-event discards it.

## Timing
- Synchroniser latency: 2 cycles.
- Debounced `state` updates on the tick edge that completes STABLE disagreeing samples.
- The pending bit is set on that same edge. `evt_valid` rises on the next edge if the output is free: 1-cycle event latency.
- Throughput: one event per cycle under continuous `evt_ready`.
- A press shorter than STABLE ticks produces no event.
- A release before LONG ticks gives press then release with no long event.

## Test plan
Bench parameters: N=4, TICK_DIV=4, STABLE=3, LONG=5.
1. Reset mid-stream: assert `rst` while `evt_valid`=1 → all outputs 0 immediately; no event after release of `rst`.
2. Clean press on btn[1] held 40 cycles, `evt_ready`=1 → `state`[1]=1 after 3 ticks; exactly one `evt_id`=1 / `evt_kind`=01; then `evt_kind`=11 five ticks later; on release, `evt_kind`=10.
3. Bounce: btn[0] toggles every 3 cycles for 30 cycles, then stays 1 → single press event only; `state`[0] never glitches.
4. Simultaneous presses on btn[0], btn[2], btn[3] on the same tick, `evt_ready`=1 → events on consecutive cycles with ids 0, 2, 3; a later press of btn[0] and btn[2] together → order 0, 2 (RR from last=3).
5. Backpressure: `evt_ready`=0 while btn[2] is pressed, held past LONG, released, pressed again → `overflow`=1; the first event is held stable; on `evt_ready`=1 the events drain as press, long, release for id 2. `ovf_clr` then clears `overflow`.
6. Glitch of 1 tick on btn[3] → no `state` change, no event, `agree` restarts.
